// File: rtl/hd44780_pkg.sv
// Shared HD44780 definitions: instruction opcodes, DDRAM layout, FSM states, AC stepping.
// Used by both the device-side responder and the host-side driver.
package hd44780_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_LO,
        ST_EXEC,
        ST_CLEAR
    } state_t;

    // Each instruction is identified by its highest set bit.
    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPLAY = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNC    = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    localparam logic [6:0] LINE0_BASE    = 7'h00;
    localparam logic [6:0] LINE1_BASE    = 7'h40;
    localparam logic [6:0] LINE0_LAST    = 7'h27;
    localparam logic [6:0] LINE1_LAST    = 7'h67;
    localparam logic [6:0] ONE_LINE_LAST = 7'h4F;
    localparam logic [7:0] BLANK_CHAR    = 8'h20;
    localparam int unsigned DDRAM_DEPTH  = 128;

    function automatic logic op_is(input logic [7:0] b, input logic [7:0] op);
        return (b & ~(op - 8'd1)) == op;
    endfunction

    // Next address counter value including the line-wrap rules of the display.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc,
                                           input logic two_line);
        logic [6:0] r;
        r = inc ? a + 7'd1 : a - 7'd1;
        if (two_line) begin
            if (inc && a == LINE0_LAST)        r = LINE1_BASE;
            else if (inc && a == LINE1_LAST)   r = LINE0_BASE;
            else if (!inc && a == LINE0_BASE)  r = LINE1_LAST;
            else if (!inc && a == LINE1_BASE)  r = LINE0_LAST;
        end else begin
            if (inc && a == ONE_LINE_LAST)     r = LINE0_BASE;
            else if (!inc && a == LINE0_BASE)  r = ONE_LINE_LAST;
        end
        return r;
    endfunction

endpackage

// File: rtl/hd44780_ddram.sv
// 128x8 display data RAM: one synchronous write port, one registered read port.
module hd44780_ddram
    import hd44780_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [DDRAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Contents are never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else     rdata <= mem[raddr];
    end

endmodule

// File: rtl/hd44780_responder.sv
// Device-side HD44780 model: strobe capture, nibble reassembly, instruction decode, DDRAM.
// Optional HD44780_RESP_SYNC_EN adds a 2-flop input synchronizer on e/rs/db.
module hd44780_responder
    import hd44780_pkg::*;
#(
    parameter int unsigned INST_CYCLES  = 10,
    parameter int unsigned CLEAR_CYCLES = 400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic [3:0] db,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] ac,
    output logic       busy,
    output logic       four_bit,
    output logic       two_line,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_dir,
    output logic       cmd_valid,
    output logic       cmd_rs,
    output logic [7:0] cmd_byte,
    output logic       viol
);

    localparam int unsigned MAXC = (CLEAR_CYCLES > INST_CYCLES) ? CLEAR_CYCLES : INST_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INST_LAST  = CW'(INST_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_CYCLES - 1);
    localparam logic [CW-1:0] FILL_END   = CW'(DDRAM_DEPTH);

    logic       e_s, rs_s;
    logic [3:0] db_s;

`ifdef HD44780_RESP_SYNC_EN
    logic [1:0] e_sync, rs_sync;
    logic [3:0] db_sync0, db_sync1;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_sync   <= '0;
            rs_sync  <= '0;
            db_sync0 <= '0;
            db_sync1 <= '0;
        end else begin
            e_sync   <= {e_sync[0], e};
            rs_sync  <= {rs_sync[0], rs};
            db_sync0 <= db;
            db_sync1 <= db_sync0;
        end
    end

    assign e_s  = e_sync[1];
    assign rs_s = rs_sync[1];
    assign db_s = db_sync1;
`else
    assign e_s  = e;
    assign rs_s = rs;
    assign db_s = db;
`endif

    logic e_q, strobe;

    always_ff @(posedge clk) begin
        if (rst) e_q <= 1'b0;
        else     e_q <= e_s;
    end

    assign strobe = e_q & ~e_s;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    hi_nib;
    logic          hi_rs;
    logic          take, accept, acc_rs, is_clear;
    logic [7:0]    acc_byte;
    logic          mem_we;
    logic [6:0]    mem_addr;
    logic [7:0]    mem_wdata;

    // Byte assembly: a strobe is taken only when not busy; a byte completes either
    // on a single 8-bit-mode strobe or on the low nibble in 4-bit mode.
    always_comb begin
        take     = strobe && !busy;
        accept   = 1'b0;
        acc_rs   = rs_s;
        acc_byte = {db_s, 4'h0};
        if (take) begin
            if (state == ST_IDLE) begin
                accept = !four_bit;
            end else if (state == ST_WAIT_LO) begin
                accept   = 1'b1;
                acc_rs   = hi_rs;
                acc_byte = {hi_nib, db_s};
            end
        end
        is_clear = accept && !acc_rs && (acc_byte == OP_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (busy && state_nxt == state) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (take) state_nxt = four_bit ? ST_WAIT_LO : ST_EXEC;
            ST_WAIT_LO: if (take) state_nxt = is_clear ? ST_CLEAR : ST_EXEC;
            ST_EXEC:    if (cnt == INST_LAST)  state_nxt = ST_IDLE;
            ST_CLEAR:   if (cnt == CLEAR_LAST) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ST_EXEC) || (state == ST_CLEAR);
        viol      = !rst && strobe &&
                    (busy || (state == ST_WAIT_LO && rs_s != hi_rs));
        mem_we    = 1'b0;
        mem_addr  = ac;
        mem_wdata = acc_byte;
        if (state == ST_CLEAR) begin
            mem_we    = cnt < FILL_END;
            mem_addr  = cnt[6:0];
            mem_wdata = BLANK_CHAR;
        end else if (accept && acc_rs) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            four_bit  <= 1'b0;
            two_line  <= 1'b0;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            inc_dir   <= 1'b1;
            ac        <= '0;
            cmd_valid <= 1'b0;
            cmd_rs    <= 1'b0;
            cmd_byte  <= '0;
            hi_nib    <= '0;
            hi_rs     <= 1'b0;
        end else begin
            cmd_valid <= accept;
            if (take && state == ST_IDLE && four_bit) begin
                hi_nib <= db_s;
                hi_rs  <= rs_s;
            end
            if (accept) begin
                cmd_rs   <= acc_rs;
                cmd_byte <= acc_byte;
                if (acc_rs) begin
                    ac <= ac_step(ac, inc_dir, two_line);
                end else if (op_is(acc_byte, OP_DDRAM)) begin
                    ac <= acc_byte[6:0];
                end else if (op_is(acc_byte, OP_CGRAM)) begin
                    // CGRAM is not modelled; the address is discarded.
                end else if (op_is(acc_byte, OP_FUNC)) begin
                    four_bit <= ~acc_byte[4];
                    two_line <= acc_byte[3];
                end else if (op_is(acc_byte, OP_SHIFT)) begin
                    if (!acc_byte[3]) ac <= ac_step(ac, acc_byte[2], two_line);
                end else if (op_is(acc_byte, OP_DISPLAY)) begin
                    {disp_on, cursor_on, blink_on} <= acc_byte[2:0];
                end else if (op_is(acc_byte, OP_ENTRY)) begin
                    inc_dir <= acc_byte[1];
                end else if (op_is(acc_byte, OP_HOME)) begin
                    ac <= '0;
                end else if (op_is(acc_byte, OP_CLEAR)) begin
                    ac      <= '0;
                    inc_dir <= 1'b1;
                end
            end
        end
    end

    hd44780_ddram u_ddram (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_addr),
        .wdata (mem_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
